// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants, FSM state
// encoding, performance event IDs and the B-type immediate decoder.
package ysyx_23060203_ifu_pkg;

  localparam logic [4:0] OP_OP_IMM = 5'b00100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  localparam int PERF_IFU_FETCH = 0;
  localparam int PERF_IFU_WAIT  = 1;
  localparam int PERF_IFU_DROP  = 2;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_23060203_ifu_bpu.sv
// Static branch predictor: backward conditional branches are taken, everything
// else (including JAL/JALR) falls through to pc+4.
module ysyx_23060203_BPU
  import ysyx_23060203_ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] npc
);

  logic taken;

  assign taken = (inst[6:2] == OP_BRANCH) && inst[31];
  assign npc   = taken ? (pc + imm_b(inst)) : (pc + 32'd4);

endmodule

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: owns the PC, issues one AR/R read at a time and hands
// the word to the decoder. Define YSYX_23060203_IFU_PERF_EN to compile in perf_event hooks.
module ysyx_23060203_ifu
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

`ifdef YSYX_23060203_IFU_PERF_EN
  int unsigned perf_cnt [3];

  initial begin
    for (int i = 0; i < 3; i++) perf_cnt[i] = 0;
  end

  function automatic void perf_event(input int id);
    perf_cnt[id] = perf_cnt[id] + 1;
  endfunction
`endif

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a source never withdraws valid or changes payload once valid is up, except
  // mem_araddr, which may follow a redirect while mem_arready is low.
  ifu_state_e  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] npc, npc_n;
  logic [31:0] inst, inst_n;
  logic [31:0] redir_pc, redir_pc_n;
  logic        drop, drop_n;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pred_npc;

  assign redir      = flush | jump_flush;
  assign target     = flush ? flush_dnpc : jump_dnpc;
  assign mem_araddr = pc;
  assign out_pc     = pc;
  assign out_inst   = inst;

  ysyx_23060203_BPU u_bpu (
    .pc   (pc),
    .inst (mem_rdata),
    .npc  (pred_npc)
  );

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    npc_n       = npc;
    inst_n      = inst;
    redir_pc_n  = redir_pc;
    drop_n      = drop;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ST_REQ: begin
        mem_arvalid = 1'b1;
        if (mem_arready) begin
          state_n = ST_WAIT;
          // Request already left with the old PC: remember to discard its data.
          if (redir) begin
            drop_n     = 1'b1;
            redir_pc_n = target;
          end
        end else if (redir) begin
          pc_n = target;
        end
      end
      ST_WAIT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          state_n = ST_REQ;
          drop_n  = 1'b0;
          if (redir) begin
            pc_n = target;
          end else if (drop) begin
            pc_n = redir_pc;
          end else begin
            inst_n  = mem_rdata;
            npc_n   = pred_npc;
            state_n = ST_HOLD;
          end
        end else if (redir) begin
          drop_n     = 1'b1;
          redir_pc_n = target;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (redir) begin
          pc_n    = target;
          state_n = ST_REQ;
        end else if (out_ready) begin
          pc_n    = npc;
          state_n = ST_REQ;
        end
      end
      default: state_n = ST_REQ;
    endcase
    if (reset) begin
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      out_valid   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      npc      <= 32'd0;
      inst     <= 32'd0;
      redir_pc <= 32'd0;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      npc      <= npc_n;
      inst     <= inst_n;
      redir_pc <= redir_pc_n;
      drop     <= drop_n;
    end
  end

`ifdef YSYX_23060203_IFU_PERF_EN
  always @(posedge clock) begin
    if (!reset) begin
      if (state != ST_HOLD) perf_event(PERF_IFU_WAIT);
      if (state == ST_WAIT && mem_rvalid) begin
        if (drop || redir) perf_event(PERF_IFU_DROP);
        else               perf_event(PERF_IFU_FETCH);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed bench for ysyx_23060203_ifu: table of prediction vectors plus
// hand-written redirect / back-pressure sequences.
module tb_ysyx_23060203_ifu;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] flush_dnpc;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;
  int ar_count = 0;

  ysyx_23060203_ifu #(.RESET_PC(32'h3000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .flush_dnpc  (flush_dnpc),
    .jump_flush  (jump_flush),
    .jump_dnpc   (jump_dnpc),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    if (!reset && mem_arvalid && mem_arready) ar_count <= ar_count + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  // driver / check tasks; outputs are sampled and inputs driven at the negedge
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starting in REQ at exp_addr: AR handshake, R after lat cycles, end in HOLD.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int lat);
    check("fetch_arvalid", {31'd0, mem_arvalid}, 32'd1);
    check("fetch_araddr", mem_araddr, exp_addr);
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    check("fetch_rready", {31'd0, mem_rready}, 32'd1);
    repeat (lat - 1) cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = word;
    cyc();
    mem_rvalid = 1'b0;
    check("fetch_out_valid", {31'd0, out_valid}, 32'd1);
    check("fetch_out_pc", out_pc, exp_addr);
    check("fetch_out_inst", out_inst, word);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] tgt);
    flush      = 1'b1;
    flush_dnpc = tgt;
    cyc();
    flush = 1'b0;
    check("redir_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    int          lat;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0;
    vecs[0] = '{32'h3000_0100, 32'hFE00_0EE3, 1, 32'h3000_00FC};  // backward beq
    vecs[1] = '{32'h3000_0100, 32'h0000_0463, 2, 32'h3000_0104};  // forward beq
    vecs[2] = '{32'h3000_0200, 32'h0000_006F, 3, 32'h3000_0204};  // jal: fall-through
    vecs[3] = '{32'h0000_0000, 32'h8000_0063, 1, 32'hFFFF_F000};  // -4096 wraps low
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0013, 2, 32'h0000_0000};  // pc+4 wraps
    vecs[5] = '{32'h3000_0000, 32'h8000_0013, 1, 32'h3000_0004};  // bit31 but not branch
    vecs[6] = '{32'h3000_0100, 32'hFE00_0EE7, 2, 32'h3000_0104};  // jalr bit31: fall-through

    reset = 1'b1; flush = 1'b0; flush_dnpc = '0; jump_flush = 1'b0; jump_dnpc = '0;
    mem_arready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0; out_ready = 1'b0;
    repeat (3) cyc();
    check("reset_arvalid", {31'd0, mem_arvalid}, 32'd0);
    check("reset_rready", {31'd0, mem_rready}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    cyc();

    // reset fetch
    do_fetch(32'h3000_0000, 32'h0000_0013, 1);
    accept();
    check("reset_next_arvalid", {31'd0, mem_arvalid}, 32'd1);
    check("reset_next_araddr", mem_araddr, 32'h3000_0004);
    do_fetch(32'h3000_0004, 32'h0000_0013, 2);

    // prediction table
    foreach (vecs[i]) begin
      flush_to(vecs[i].start_pc);
      do_fetch(vecs[i].start_pc, vecs[i].word, vecs[i].lat);
      accept();
      check("vec_next_araddr", mem_araddr, vecs[i].exp_npc);
      do_fetch(vecs[i].exp_npc, 32'h0000_0013, 1);
    end

    // back-pressure
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_pc", out_pc, vecs[6].exp_npc);
      check("bp_out_inst", out_inst, 32'h0000_0013);
      check("bp_arvalid", {31'd0, mem_arvalid}, 32'd0);
    end
    accept();
    check("bp_next_araddr", mem_araddr, vecs[6].exp_npc + 32'd4);

    // drop on redirect in WAIT
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0200;
    cyc();
    jump_flush = 1'b0;
    repeat (2) cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    check("drop_wait_out_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    mem_rvalid = 1'b0;
    check("drop_out_valid", {31'd0, out_valid}, 32'd0);
    check("drop_arvalid", {31'd0, mem_arvalid}, 32'd1);
    check("drop_araddr", mem_araddr, 32'h3000_0200);

    // redirect in the same cycle as the AR handshake
    mem_arready = 1'b1; jump_flush = 1'b1; jump_dnpc = 32'h3000_0300;
    cyc();
    mem_arready = 1'b0; jump_flush = 1'b0;
    check("arhs_rready", {31'd0, mem_rready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    cyc();
    mem_rvalid = 1'b0;
    check("arhs_out_valid", {31'd0, out_valid}, 32'd0);
    check("arhs_araddr", mem_araddr, 32'h3000_0300);

    // later redirect overwrites, then redirect coinciding with rvalid wins
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0500;
    cyc();
    jump_dnpc = 32'h3000_0580;
    cyc();
    jump_flush = 1'b0;
    cyc();
    mem_rvalid = 1'b1;
    cyc();
    mem_rvalid = 1'b0;
    check("overwrite_araddr", mem_araddr, 32'h3000_0580);
    mem_arready = 1'b1;
    cyc();
    mem_arready = 1'b0;
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0700;
    cyc();
    jump_flush = 1'b0;
    mem_rvalid = 1'b1; flush = 1'b1; flush_dnpc = 32'h3000_0780;
    cyc();
    mem_rvalid = 1'b0; flush = 1'b0;
    check("rvalid_redir_out_valid", {31'd0, out_valid}, 32'd0);
    check("rvalid_redir_araddr", mem_araddr, 32'h3000_0780);
    do_fetch(32'h3000_0780, 32'h0000_0013, 1);

    // redirect priority in HOLD with a same-cycle out handshake
    flush = 1'b1; flush_dnpc = 32'h3000_0400;
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0200;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0; jump_flush = 1'b0; out_ready = 1'b0;
    check("prio_out_valid", {31'd0, out_valid}, 32'd0);
    check("prio_arvalid", {31'd0, mem_arvalid}, 32'd1);
    check("prio_araddr", mem_araddr, 32'h3000_0400);

    // stalled AR with redirect in cycle 2
    n0 = ar_count;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        jump_flush = 1'b1; jump_dnpc = 32'h3000_0800;
      end
      cyc();
      jump_flush = 1'b0;
      check("stall_arvalid", {31'd0, mem_arvalid}, 32'd1);
      check("stall_araddr", mem_araddr, (i >= 1) ? 32'h3000_0800 : 32'h3000_0400);
    end
    do_fetch(32'h3000_0800, 32'h0000_0013, 1);
    check("stall_one_read", ar_count - n0, 32'd1);
    accept();
    check("stall_next_araddr", mem_araddr, 32'h3000_0804);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
